// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, mode codes,
// sequencer state encoding and the state-selection helper.
package led_seq_pkg;

    // Word addresses on the register bus
    localparam logic [1:0] ADR_CTRL    = 2'd0;
    localparam logic [1:0] ADR_PATTERN = 2'd1;
    localparam logic [1:0] ADR_PERIOD  = 2'd2;
    localparam logic [1:0] ADR_STATUS  = 2'd3;

    // CTRL.MODE codes
    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ROT_L  = 2'b10;
    localparam logic [1:0] MODE_ROT_R  = 2'b11;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_STATIC    = 3'd1,
        ST_BLINK_ON  = 3'd2,
        ST_BLINK_OFF = 3'd3,
        ST_ROTATE    = 3'd4
    } state_t;

    // State a sequence starts in for a given CTRL value {EN, MODE}
    function automatic state_t entry_state(input logic [2:0] ctrl);
        state_t s;
        if (!ctrl[2])
            s = ST_OFF;
        else if (ctrl[1:0] == MODE_STATIC)
            s = ST_STATIC;
        else if (ctrl[1:0] == MODE_BLINK)
            s = ST_BLINK_ON;
        else
            s = ST_ROTATE;
        return s;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Prescaler: counts 0..max(period,1)-1 and pulses tick on the last count.
module led_seq_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;

    // A period of zero is treated as one, giving a tick every cycle
    assign last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick = (cnt == last);

    // Counter: synchronous active-low reset, clear overrides counting
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + PERIOD_W'(1);
    end

endmodule

// File: rtl/led_seq.sv
// LED sequencer: bus-programmed static / blink / rotate patterns driving
// 16 active-low LEDs, with a one-cycle-per-access register handshake.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic [15:0] LED
);

    logic [2:0]          ctrl;
    logic [15:0]         pattern;
    logic [PERIOD_W-1:0] period;

    state_t      state, state_nxt;
    logic [15:0] rot;
    logic [15:0] step;
    logic [15:0] disp;

    logic        access, wr, wr_ctrl, wr_pat, wr_per, restart;
    logic [2:0]  ctrl_new;
    logic [15:0] pat_new;
    logic        tick_raw, tick;
    logic [31:0] rdata;
    logic        unused_dat;

    // An access is accepted only when no ack is outstanding, so a held
    // strobe is served on alternate cycles
    assign access  = STB_I & ~ACK_O;
    assign wr      = access & WE_I;
    assign wr_ctrl = wr & (ADR_I == ADR_CTRL);
    assign wr_pat  = wr & (ADR_I == ADR_PATTERN);
    assign wr_per  = wr & (ADR_I == ADR_PERIOD);
    assign restart = wr_ctrl | wr_pat;

    // Values the restarted sequence must see on the edge of the write
    assign ctrl_new = wr_ctrl ? DAT_I[2:0]  : ctrl;
    assign pat_new  = wr_pat  ? DAT_I[15:0] : pattern;

    // Any configuration write swallows a coinciding tick
    assign tick = tick_raw & ~restart & ~wr_per;

    assign unused_dat = ^DAT_I;

    led_seq_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk    (CLK_I),
        .rst    (RST_I),
        .clr    (restart | wr_per | (state == ST_OFF)),
        .period (period),
        .tick   (tick_raw)
    );

    // Read multiplexer over the register map
    always_comb begin
        // NOTE: default every combinational output first so no path
        // leaves it unassigned and infers a latch.
        rdata = '0;
        case (ADR_I)
            ADR_CTRL:    rdata[2:0]  = ctrl;
            ADR_PATTERN: rdata[15:0] = pattern;
            ADR_PERIOD:  rdata       = 32'(period);
            default:     rdata       = {13'b0, state, step};
        endcase
    end

    // Bus handshake, read data and configuration registers
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            ACK_O   <= 1'b0;
            DAT_O   <= '0;
            ctrl    <= '0;
            pattern <= '0;
            period  <= '0;
        end else begin
            ACK_O <= access;
            DAT_O <= access ? rdata : '0;
            if (wr_ctrl) ctrl    <= DAT_I[2:0];
            if (wr_pat)  pattern <= DAT_I[15:0];
            if (wr_per)  period  <= DAT_I[PERIOD_W-1:0];
        end
    end

    // Sequencer state register
    always_ff @(posedge CLK_I) begin
        if (!RST_I)
            state <= ST_OFF;
        else
            state <= state_nxt;
    end

    // Sequencer next state: restart re-enters, ticks toggle the blink phase
    always_comb begin
        state_nxt = state;
        if (restart)
            state_nxt = entry_state(ctrl_new);
        else if (tick) begin
            case (state)
                ST_BLINK_ON:  state_nxt = ST_BLINK_OFF;
                ST_BLINK_OFF: state_nxt = ST_BLINK_ON;
                default:      state_nxt = state;
            endcase
        end
    end

    // Rotating pattern and step counter
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            rot  <= '0;
            step <= '0;
        end else if (restart) begin
            rot  <= pat_new;
            step <= '0;
        end else if (tick) begin
            if (state == ST_ROTATE)
                rot <= (ctrl[1:0] == MODE_ROT_R) ? {rot[0], rot[15:1]}
                                                 : {rot[14:0], rot[15]};
            if (state == ST_BLINK_ON || state == ST_BLINK_OFF || state == ST_ROTATE)
                step <= step + 16'd1;
        end
    end

    // Sequencer output: displayed pattern per state
    always_comb begin
        disp = '0;
        case (state)
            ST_STATIC, ST_BLINK_ON: disp = pattern;
            ST_ROTATE:              disp = rot;
            default:                disp = '0;
        endcase
    end

    assign LED = ~disp;

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq: reset, static, blink, rotate, collision,
// held-strobe handshake and ignored STATUS writes.
module tb_led_seq;
    import led_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack;
    logic [15:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    led_seq #(.PERIOD_W(24)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .STB_I (stb),
        .WE_I  (we),
        .ADR_I (adr),
        .DAT_I (dat_w),
        .DAT_O (dat_r),
        .ACK_O (ack),
        .LED   (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge, commit on the next rising edge, return at the
    // following falling edge with the strobe released
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        @(negedge clk);
        check("wr_ack", {31'b0, ack}, 32'd1);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        check("rd_ack", {31'b0, ack}, 32'd1);
        d = dat_r;
        stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        // Reset for two cycles
        @(negedge clk);
        @(negedge clk);
        check("rst_led", {16'b0, led}, 32'h0000_FFFF);
        check("rst_ack", {31'b0, ack}, 32'd0);
        rst = 1'b1;
        bus_read(ADR_STATUS, rd);
        check("rst_status", rd, 32'h0000_0000);

        // Reset landing on a write edge drops the ack and the write
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = ADR_PATTERN; dat_w = 32'h0000_ABCD; rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", {31'b0, ack}, 32'd0);
        stb = 1'b0; we = 1'b0; rst = 1'b1;
        bus_read(ADR_PATTERN, rd);
        check("rst_mid_pat", rd, 32'h0000_0000);

        // Static pattern
        bus_write(ADR_PATTERN, 32'h0000_00F0);
        bus_write(ADR_CTRL, 32'h0000_0004);
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            check("static_led", {16'b0, led}, 32'h0000_FF0F);
        end
        bus_read(ADR_STATUS, rd);
        check("static_status", rd, 32'h0001_0000);

        // Blink with PERIOD=3: three cycles on, three off
        bus_write(ADR_PERIOD, 32'd3);
        bus_write(ADR_PATTERN, 32'h0000_AAAA);
        bus_write(ADR_CTRL, 32'h0000_0005);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            check("blink_led", {16'b0, led}, ((k / 3) % 2 == 0) ? 32'h0000_5555 : 32'h0000_FFFF);
        end
        bus_read(ADR_STATUS, rd);
        check("blink_status", rd, 32'h0002_0004);

        // Rotate left then right with a tick every cycle
        bus_write(ADR_PERIOD, 32'd0);
        bus_write(ADR_PATTERN, 32'h0000_8001);
        bus_write(ADR_CTRL, 32'h0000_0006);
        check("rotl_0", {16'b0, led}, 32'h0000_7FFE);
        @(negedge clk);
        check("rotl_1", {16'b0, led}, 32'h0000_FFFC);
        @(negedge clk);
        check("rotl_2", {16'b0, led}, 32'h0000_FFF9);
        bus_write(ADR_CTRL, 32'h0000_0007);
        check("rotr_0", {16'b0, led}, 32'h0000_7FFE);
        @(negedge clk);
        check("rotr_1", {16'b0, led}, 32'h0000_3FFF);
        @(negedge clk);
        check("rotr_2", {16'b0, led}, 32'h0000_9FFF);

        // Collision: PATTERN write lands on the second edge after PERIOD=2
        bus_write(ADR_PERIOD, 32'd2);
        bus_write(ADR_PATTERN, 32'h0000_1234);
        check("coll_led", {16'b0, led}, 32'h0000_EDCB);
        bus_read(ADR_STATUS, rd);
        check("coll_status", rd, 32'h0004_0000);
        check("coll_next", {16'b0, led}, 32'h0000_F6E5);

        // Held read strobe: ack on alternate cycles
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = ADR_PATTERN;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hs_ack", {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0)
                check("hs_data", dat_r, 32'h0000_1234);
        end
        stb = 1'b0;

        // STATUS is read-only; other registers read back
        bus_write(ADR_STATUS, 32'hFFFF_FFFF);
        bus_read(ADR_CTRL, rd);
        check("ctrl_rd", rd, 32'h0000_0007);
        bus_read(ADR_PERIOD, rd);
        check("period_rd", rd, 32'h0000_0002);

        // Reset while running
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_led", {16'b0, led}, 32'h0000_FFFF);
        rst = 1'b1;
        bus_read(ADR_CTRL, rd);
        check("rst2_ctrl", rd, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
